// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stall, two-slot redirect kill, memory freeze.
// Ports: clk/rst, inst_id/inst_ex, redirect_ex, mem_busy, cnt_clr in;
//        stall_if/stall_id/bubble_ex/flush_id/stall_all, hz_state, counters out.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_id,
  input  logic [31:0]      inst_ex,
  input  logic             redirect_ex,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             stall_all,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_KILL  = 2'd1;
  localparam logic [1:0] S_MWAIT = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [1:0] sv_state;
  logic [1:0] nxt_state;
  logic [1:0] eff_state;
  logic       v_ex;
  logic       v_mem;

  logic [6:0] op_id;
  logic [6:0] op_ex;
  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       id_rs1;
  logic       id_rs2;
  logic       load_use;
  logic       unused_bits;

  assign op_id  = inst_id[6:0];
  assign rs1_id = inst_id[19:15];
  assign rs2_id = inst_id[24:20];
  assign op_ex  = inst_ex[6:0];
  assign rd_ex  = inst_ex[11:7];

  assign unused_bits = ^{inst_id[31:25], inst_id[14:7],
                         inst_ex[31:12]};

  assign id_rs1 = !(op_id == OP_LUI || op_id == OP_AUIPC ||
                    op_id == OP_JAL);
  assign id_rs2 = (op_id == OP_REG) || (op_id == OP_STORE) ||
                  (op_id == OP_BRANCH);

  assign load_use = v_ex && (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((rd_ex == rs1_id && id_rs1) ||
                     (rd_ex == rs2_id && id_rs2));

  // Leaving MWAIT behaves as the saved state in the same cycle.
  assign eff_state = (hz_state == S_MWAIT) ? sv_state : hz_state;

  logic go;
  logic c_mb;
  logic c_kill;
  logic c_redir;
  logic c_lu;

  assign go      = !rst && !mem_busy;
  assign c_mb    = !rst && mem_busy;
  assign c_kill  = go && (eff_state == S_KILL);
  assign c_redir = go && (eff_state == S_RUN) && redirect_ex && v_ex;
  assign c_lu    = go && (eff_state == S_RUN) && !c_redir && load_use;

  assign stall_all = mem_busy;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    nxt_state = S_RUN;
    unique case (1'b1)
      rst: begin
        nxt_state = S_RUN;
      end
      c_mb: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        nxt_state = S_MWAIT;
      end
      c_kill: begin
        flush_id  = 1'b1;
        nxt_state = S_RUN;
      end
      c_redir: begin
        flush_id  = 1'b1;
        nxt_state = S_KILL;
      end
      c_lu: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        nxt_state = S_RUN;
      end
      default: begin
        nxt_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_state <= S_RUN;
      sv_state <= S_RUN;
      v_ex     <= 1'b0;
      v_mem    <= 1'b0;
    end else begin
      hz_state <= nxt_state;
      if (mem_busy && hz_state != S_MWAIT)
        sv_state <= hz_state;
      if (!mem_busy) begin
        v_mem <= v_ex;
        v_ex  <= !(flush_id | bubble_ex);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (v_mem && !mem_busy)
        instret_cnt <= instret_cnt + CNT_W'(1);
      if (stall_if)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard queue.
// Narrow counters so wrap-around is reached within the run.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW5     = 32'h0000_A283;
  localparam logic [31:0] LW0     = 32'h0000_A003;
  localparam logic [31:0] ADD_RS1 = 32'h0022_8333;
  localparam logic [31:0] ADD_RS2 = 32'h0051_0333;
  localparam logic [31:0] ADD_X0  = 32'h0020_0333;
  localparam logic [31:0] LUI5    = 32'h0002_8337;
  localparam logic [31:0] ADDI5   = 32'h0051_0313;
  localparam logic [31:0] SW5     = 32'h0051_2023;

  // {stall_if, stall_id, bubble_ex, flush_id}
  localparam logic [3:0] E0   = 4'b0000;
  localparam logic [3:0] ELU  = 4'b1110;
  localparam logic [3:0] EFL  = 4'b0001;
  localparam logic [3:0] EMB  = 4'b1100;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst_id;
  logic [31:0]   inst_ex;
  logic          redirect_ex;
  logic          mem_busy;
  logic          cnt_clr;
  logic          stall_if;
  logic          stall_id;
  logic          bubble_ex;
  logic          flush_id;
  logic          stall_all;
  logic [1:0]    hz_state;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instret_cnt;
  logic [CW-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .inst_id(inst_id), .inst_ex(inst_ex),
    .redirect_ex(redirect_ex), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .stall_all(stall_all), .hz_state(hz_state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    ctl;
    logic [1:0]    st;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ret;
    logic [CW-1:0] stl;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [CW-1:0] cyc_m = '0;
  logic [CW-1:0] ret_m = '0;
  logic [CW-1:0] stl_m = '0;
  logic          vex_m = 1'b0;
  logic          vmem_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] id,
                      input logic [31:0] ex, input logic red,
                      input logic mb, input logic clr,
                      input logic [3:0] e, input logic [1:0] est);
    exp_t pe;
    exp_t ge;
    rst         = r;
    inst_id     = id;
    inst_ex     = ex;
    redirect_ex = red;
    mem_busy    = mb;
    cnt_clr     = clr;
    pe.ctl = {e, mb};
    pe.st  = est;
    pe.cyc = cyc_m;
    pe.ret = ret_m;
    pe.stl = stl_m;
    q.push_back(pe);
    @(negedge clk);
    ge = q.pop_front();
    chk("ctl", {27'd0, stall_if, stall_id, bubble_ex, flush_id,
                stall_all}, {27'd0, ge.ctl});
    chk("hz_state", {30'd0, hz_state}, {30'd0, ge.st});
    chk("cycle_cnt", 32'(cycle_cnt), 32'(ge.cyc));
    chk("instret_cnt", 32'(instret_cnt), 32'(ge.ret));
    chk("stall_cnt", 32'(stall_cnt), 32'(ge.stl));
    @(posedge clk);
    #1;
    if (r) begin
      cyc_m = '0; ret_m = '0; stl_m = '0;
      vex_m = 1'b0; vmem_m = 1'b0;
    end else begin
      if (clr) begin
        cyc_m = '0; ret_m = '0; stl_m = '0;
      end else begin
        cyc_m = cyc_m + 1'b1;
        if (vmem_m && !mb) ret_m = ret_m + 1'b1;
        if (e[3]) stl_m = stl_m + 1'b1;
      end
      if (!mb) begin
        vmem_m = vex_m;
        vex_m  = !(e[0] | e[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; inst_id = NOP; inst_ex = NOP;
    redirect_ex = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, and stall_all still follows mem_busy
    step(1, NOP, NOP, 0, 0, 0, E0, 0);
    step(1, NOP, NOP, 0, 1, 0, E0, 0);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // load-use, then bubble in EX
    step(0, ADD_RS1, LW5, 0, 0, 0, ELU, 0);
    step(0, ADD_RS1, LW5, 0, 0, 0, E0, 0);
    step(0, ADD_X0, LW0, 0, 0, 0, E0, 0);
    step(0, ADD_RS2, LW5, 0, 0, 0, ELU, 0);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    step(0, LUI5, LW5, 0, 0, 0, E0, 0);
    step(0, ADDI5, LW5, 0, 0, 0, E0, 0);
    step(0, SW5, LW5, 0, 0, 0, ELU, 0);
    // redirect with v_ex=0 is ignored
    step(0, NOP, NOP, 1, 0, 0, E0, 0);
    // redirect + load-use: redirect wins, then KILL
    step(0, ADD_RS1, LW5, 1, 0, 0, EFL, 0);
    step(0, ADD_RS1, LW5, 1, 0, 0, EFL, 1);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // redirect held through 3 busy cycles
    step(0, NOP, NOP, 1, 1, 0, EMB, 0);
    step(0, NOP, NOP, 1, 1, 0, EMB, 2);
    step(0, NOP, NOP, 1, 1, 0, EMB, 2);
    step(0, NOP, NOP, 1, 0, 0, EFL, 2);
    step(0, NOP, NOP, 0, 0, 0, EFL, 1);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // busy during KILL: one more flush on release
    step(0, NOP, NOP, 1, 0, 0, EFL, 0);
    step(0, NOP, NOP, 0, 1, 0, EMB, 1);
    step(0, NOP, NOP, 0, 1, 0, EMB, 2);
    step(0, NOP, NOP, 0, 0, 0, EFL, 2);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // counter clear
    step(0, NOP, NOP, 0, 0, 1, E0, 0);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // reset during MWAIT
    step(0, NOP, NOP, 0, 1, 0, EMB, 0);
    step(0, NOP, NOP, 0, 1, 0, EMB, 2);
    step(1, NOP, NOP, 0, 1, 0, E0, 2);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    // alternate stalls long enough for every counter to wrap
    for (int i = 0; i < 17; i++) begin
      step(0, ADD_RS1, LW5, 0, 0, 0, ELU, 0);
      step(0, ADD_RS1, LW5, 0, 0, 0, E0, 0);
    end
    // clear coinciding with an increment
    step(0, ADD_RS1, LW5, 0, 0, 1, ELU, 0);
    step(0, NOP, NOP, 0, 0, 0, E0, 0);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
